// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage MIPS core. The forwarding unit
// resolves the dependences it can bypass. This block handles the rest:
//   - load-use stalls
//   - jump-register stalls, including the 2-cycle jr-after-load stall
//   - flushes on taken branches and jumps
//   - freezing the whole pipe while data memory is busy
// It also keeps saturating stall and flush event counters.
// The control outputs are combinational from the state and the inputs, so a
// stall takes effect in the same cycle the hazard becomes visible.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1,
   input  logic [4:0]       Rt1,
   input  logic             UseRs1,
   input  logic             UseRt1,
   input  logic             Jump1,
   input  logic             JumpReg1,
   input  logic             RegWr2,
   input  logic             MemRead2,
   input  logic [4:0]       RegWrAddr2,
   input  logic             MemRead3,
   input  logic [4:0]       RegWrAddr3,
   input  logic             BranchTaken2,
   input  logic             MemBusy,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             IDEXFlush,
   output logic             PipeWrite,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   // RUN: normal operation. HOLD1: one more stall is owed after a jr-after-load.
   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_HOLD1 = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_lu;        // load in EX feeds an operand of the ID instruction
   logic w_jh;        // jr/jalr target register still being produced
   logic w_jl;        // jr/jalr target produced by a load in EX: two stalls needed
   logic w_stall_inc;
   logic w_flush_inc;

   // Hazard detection terms. Register 0 never produces a hazard.
   always_comb begin
      w_lu = MemRead2 && (RegWrAddr2 != 5'd0) &&
             ((UseRs1 && (RegWrAddr2 == Rs1)) || (UseRt1 && (RegWrAddr2 == Rt1)));
      w_jh = JumpReg1 && (Rs1 != 5'd0) &&
             ((RegWr2 && (RegWrAddr2 == Rs1)) || (MemRead3 && (RegWrAddr3 == Rs1)));
      w_jl = JumpReg1 && MemRead2 && (RegWrAddr2 != 5'd0) && (RegWrAddr2 == Rs1);
   end

   // Next-state and pipeline controls. Priority is:
   //   reset > memory busy > taken branch > stall > jump.
   always_comb begin
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      IFIDFlush   = 1'b0;
      IDEXFlush   = 1'b0;
      PipeWrite   = 1'b1;
      w_stall_inc = 1'b0;
      w_flush_inc = 1'b0;
      w_state_nxt = r_state;
      if (reset) begin
         PCWrite     = 1'b0;
         IFIDWrite   = 1'b0;
         PipeWrite   = 1'b0;
         IFIDFlush   = 1'b1;
         IDEXFlush   = 1'b1;
         w_state_nxt = ST_RUN;
      end else if (MemBusy) begin
         // Freeze everything; a pending HOLD1 is kept.
         PCWrite     = 1'b0;
         IFIDWrite   = 1'b0;
         PipeWrite   = 1'b0;
         w_state_nxt = r_state;
      end else if (BranchTaken2) begin
         // Wrong-path instructions in IF/ID and ID/EX are squashed.
         // Any owed stall is moot.
         IFIDFlush   = 1'b1;
         IDEXFlush   = 1'b1;
         w_flush_inc = 1'b1;
         w_state_nxt = ST_RUN;
      end else begin
         case (r_state)
            ST_HOLD1: begin
               // Second stall cycle of the jr-after-load sequence; hazards ignored.
               PCWrite     = 1'b0;
               IFIDWrite   = 1'b0;
               IDEXFlush   = 1'b1;
               w_stall_inc = 1'b1;
               w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
               if (w_lu || w_jh) begin
                  PCWrite     = 1'b0;
                  IFIDWrite   = 1'b0;
                  IDEXFlush   = 1'b1;
                  w_stall_inc = 1'b1;
                  w_state_nxt = w_jl ? ST_HOLD1 : ST_RUN;
               end else if (Jump1 || JumpReg1) begin
                  // One-bubble jump penalty: drop the sequential fetch.
                  IFIDFlush   = 1'b1;
                  w_flush_inc = 1'b1;
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            default: begin
               w_state_nxt = ST_RUN;
            end
         endcase
      end
   end

   // State register and saturating event counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_stall_cnt <= {CNT_W{1'b0}};
         r_flush_cnt <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
         if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end else begin
            r_flush_cnt <= r_flush_cnt;
         end
      end
   end

   assign StallCount = r_stall_cnt;
   assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed scenarios followed by randomized stimulus. Every cycle is
// compared against a behavioural model of the hazard rules. The DUT is built
// with 4-bit counters so that saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int CW  = 4;
   localparam int MAX = 15;

   logic          clk = 1'b0;
   logic          reset, MemBusy, BranchTaken2, Jump1, JumpReg1;
   logic          MemRead2, RegWr2, MemRead3, UseRs1, UseRt1;
   logic [4:0]    Rs1, Rt1, RegWrAddr2, RegWrAddr3;
   logic          PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, PipeWrite;
   logic [CW-1:0] StallCount, FlushCount;

   int n_vec = 0;
   int n_err = 0;

   // Model state: is an extra stall owed, the event totals, and
   // whether the counters are defined yet (i.e. a reset edge has been seen).
   bit m_owed  = 1'b0;
   int m_stall = 0;
   int m_flush = 0;
   bit m_known = 1'b0;

   hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Rs1(Rs1), .Rt1(Rt1), .UseRs1(UseRs1), .UseRt1(UseRt1),
      .Jump1(Jump1), .JumpReg1(JumpReg1), .RegWr2(RegWr2), .MemRead2(MemRead2),
      .RegWrAddr2(RegWrAddr2), .MemRead3(MemRead3), .RegWrAddr3(RegWrAddr3),
      .BranchTaken2(BranchTaken2), .MemBusy(MemBusy), .PCWrite(PCWrite),
      .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
      .PipeWrite(PipeWrite), .StallCount(StallCount), .FlushCount(FlushCount)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   // Apply one cycle of inputs. Compare the outputs with the model, then
   // advance the model across the coming clock edge.
   task automatic cycle(input bit rst, input bit busy, input bit br, input bit j, input bit jr,
                        input bit mr2, input bit rw2, input logic [4:0] wa2,
                        input bit mr3, input logic [4:0] wa3,
                        input bit urs, input logic [4:0] rs, input bit urt, input logic [4:0] rt);
      bit lu, jh, jl;
      bit e_pc, e_ifid, e_iff, e_idf, e_pipe;
      @(negedge clk);
      reset = rst; MemBusy = busy; BranchTaken2 = br; Jump1 = j; JumpReg1 = jr;
      MemRead2 = mr2; RegWr2 = rw2; RegWrAddr2 = wa2; MemRead3 = mr3; RegWrAddr3 = wa3;
      UseRs1 = urs; Rs1 = rs; UseRt1 = urt; Rt1 = rt;
      #1;
      lu = mr2 && wa2 != 0 && ((urs && wa2 == rs) || (urt && wa2 == rt));
      jh = jr && rs != 0 && ((rw2 && wa2 == rs) || (mr3 && wa3 == rs));
      jl = jr && mr2 && wa2 != 0 && wa2 == rs;
      if (m_known) begin
         check_eq("StallCount", 32'(StallCount), 32'(m_stall));
         check_eq("FlushCount", 32'(FlushCount), 32'(m_flush));
      end
      // Default expectation: normal flow.
      {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b11001;
      if (rst) begin
         {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b00110;
         m_owed = 0; m_stall = 0; m_flush = 0; m_known = 1;
      end else if (busy) begin
         {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b00000;
      end else if (br) begin
         {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b11111;
         m_flush = (m_flush < MAX) ? m_flush + 1 : MAX;
         m_owed = 0;
      end else if (m_owed || lu || jh) begin
         {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b00011;
         m_stall = (m_stall < MAX) ? m_stall + 1 : MAX;
         m_owed = !m_owed && jl;
      end else if (j || jr) begin
         {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b11101;
         m_flush = (m_flush < MAX) ? m_flush + 1 : MAX;
      end
      check_eq("PCWrite",   32'(PCWrite),   32'(e_pc));
      check_eq("IFIDWrite", 32'(IFIDWrite), 32'(e_ifid));
      check_eq("IFIDFlush", 32'(IFIDFlush), 32'(e_iff));
      check_eq("IDEXFlush", 32'(IDEXFlush), 32'(e_idf));
      check_eq("PipeWrite", 32'(PipeWrite), 32'(e_pipe));
   endtask

   // Quiet cycle: no hazards, no control flow changes.
   task automatic idle();
      cycle(0,0,0,0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,5'd0);
   endtask

   task automatic do_reset();
      cycle(1,0,0,0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,5'd0);
   endtask

   initial begin
      do_reset();
      do_reset();
      // Load-use: lw $5 in EX, add reading $5 in ID.
      cycle(0,0,0,0,0, 1,1,5'd5, 0,5'd0, 1,5'd5, 0,5'd0);
      idle();
      check_eq("lu_stall_total", 32'(StallCount), 32'd1);
      // jr $8 after lw $8: two stalls, then the jump bubble.
      cycle(0,0,0,0,1, 1,1,5'd8, 0,5'd0, 1,5'd8, 0,5'd0);
      cycle(0,0,0,0,1, 0,0,5'd0, 1,5'd8, 1,5'd8, 0,5'd0);
      cycle(0,0,0,0,1, 0,0,5'd0, 0,5'd0, 1,5'd8, 0,5'd0);
      idle();
      check_eq("jl_stall_total", 32'(StallCount), 32'd3);
      check_eq("jl_flush_total", 32'(FlushCount), 32'd1);
      // jr-after-load followed by a 3-cycle freeze; the owed stall must survive.
      do_reset();
      cycle(0,0,0,0,1, 1,1,5'd9, 0,5'd0, 1,5'd9, 0,5'd0);
      for (int i = 0; i < 3; i++) cycle(0,1,0,0,1, 0,0,5'd0, 1,5'd9, 1,5'd9, 0,5'd0);
      cycle(0,0,0,0,1, 0,0,5'd0, 0,5'd0, 1,5'd9, 0,5'd0);
      idle();
      check_eq("busy_hold_stalls", 32'(StallCount), 32'd2);
      // Taken branch beats a load-use hazard; a branch while HOLD1 is pending cancels it.
      cycle(0,0,1,0,0, 1,1,5'd3, 0,5'd0, 1,5'd3, 0,5'd0);
      cycle(0,0,0,0,1, 1,1,5'd4, 0,5'd0, 1,5'd4, 0,5'd0);
      cycle(0,0,1,0,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,5'd0);
      idle();
      // Register 0 never stalls; a plain j only flushes IF/ID.
      cycle(0,0,0,0,1, 1,1,5'd0, 1,5'd0, 1,5'd0, 1,5'd0);
      cycle(0,0,0,1,0, 0,0,5'd0, 0,5'd0, 0,5'd0, 0,5'd0);
      // Reset in the middle of HOLD1: no residual stall afterwards.
      cycle(0,0,0,0,1, 1,1,5'd7, 0,5'd0, 1,5'd7, 0,5'd0);
      do_reset();
      idle();
      // Saturation: 20 back-to-back load-use cycles.
      for (int i = 0; i < 20; i++) cycle(0,0,0,0,0, 1,1,5'd6, 0,5'd0, 0,5'd0, 1,5'd6);
      idle();
      check_eq("stall_saturated", 32'(StallCount), 32'd15);
      do_reset();
      idle();
      check_eq("stall_after_reset", 32'(StallCount), 32'd0);
      // Randomized traffic with small register numbers so matches are frequent.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0,59) == 0, $urandom_range(0,5) == 0, $urandom_range(0,7) == 0,
               $urandom_range(0,6) == 0, $urandom_range(0,3) == 0,
               $urandom_range(0,1) == 0, $urandom_range(0,1) == 0, 5'($urandom_range(0,3)),
               $urandom_range(0,2) == 0, 5'($urandom_range(0,3)),
               $urandom_range(0,1) == 0, 5'($urandom_range(0,3)),
               $urandom_range(0,1) == 0, 5'($urandom_range(0,3)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
